tilelink_ul_demux_1mns: RTL and testbench

TILELINK_UL_DEMUX_1MNS -- requirements
Module: tilelink_ul_demux_1mns

---
 rtl/tilelink_ul_demux_1mns.sv | 217 +++++++++++++++++++++
 tb/tb_tilelink_ul_demux_1mns.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilelink_ul_demux_1mns.sv
// TileLink-UL 1:N address demux with in-order target locking,
// outstanding-transaction limit and local decode-error responder.
module tilelink_ul_demux_1mns #(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_OPCODE_WIDTH = 3,
  parameter int TL_PARAM_WIDTH  = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int NUM_SLAVES      = 3,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter longint unsigned SLAVE_SPAN = 512,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic                       m_a_valid,
  input  logic [TL_OPCODE_WIDTH-1:0] m_a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  m_a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   m_a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   m_a_size,
  input  logic [TL_STRB_WIDTH-1:0]   m_a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   m_a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] m_a_source,
  output logic                       m_a_ready,
  output logic                       m_d_valid,
  output logic [TL_OPCODE_WIDTH-1:0] m_d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  m_d_param,
  output logic [TL_SIZE_WIDTH-1:0]   m_d_size,
  output logic [TL_SINK_WIDTH-1:0]   m_d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] m_d_source,
  output logic [TL_DATA_WIDTH-1:0]   m_d_data,
  output logic                       m_d_error,
  input  logic                       m_d_ready,
  output logic [NUM_SLAVES-1:0]                 s_a_valid,
  output logic [NUM_SLAVES*TL_OPCODE_WIDTH-1:0] s_a_opcode,
  output logic [NUM_SLAVES*TL_PARAM_WIDTH-1:0]  s_a_param,
  output logic [NUM_SLAVES*TL_ADDR_WIDTH-1:0]   s_a_address,
  output logic [NUM_SLAVES*TL_SIZE_WIDTH-1:0]   s_a_size,
  output logic [NUM_SLAVES*TL_STRB_WIDTH-1:0]   s_a_mask,
  output logic [NUM_SLAVES*TL_DATA_WIDTH-1:0]   s_a_data,
  output logic [NUM_SLAVES*TL_SOURCE_WIDTH-1:0] s_a_source,
  input  logic [NUM_SLAVES-1:0]                 s_a_ready,
  input  logic [NUM_SLAVES-1:0]                 s_d_valid,
  input  logic [NUM_SLAVES*TL_OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [NUM_SLAVES*TL_PARAM_WIDTH-1:0]  s_d_param,
  input  logic [NUM_SLAVES*TL_SIZE_WIDTH-1:0]   s_d_size,
  input  logic [NUM_SLAVES*TL_SINK_WIDTH-1:0]   s_d_sink,
  input  logic [NUM_SLAVES*TL_SOURCE_WIDTH-1:0] s_d_source,
  input  logic [NUM_SLAVES*TL_DATA_WIDTH-1:0]   s_d_data,
  input  logic [NUM_SLAVES-1:0]                 s_d_error,
  output logic [NUM_SLAVES-1:0]                 s_d_ready,
  output logic [7:0]                            decode_err_cnt
);

  localparam int OW = TL_OPCODE_WIDTH;
  localparam int PW = TL_PARAM_WIDTH;
  localparam int AW = TL_ADDR_WIDTH;
  localparam int ZW = TL_SIZE_WIDTH;
  localparam int MW = TL_STRB_WIDTH;
  localparam int DW = TL_DATA_WIDTH;
  localparam int SW = TL_SOURCE_WIDTH;
  localparam int KW = TL_SINK_WIDTH;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [AW:0]    BASE     = (AW+1)'(BASE_ADDR);
  localparam logic [AW-1:0]  SPAN     = AW'(SLAVE_SPAN);
  localparam logic [AW-1:0]  TOP_SPAN = AW'(NUM_SLAVES * SLAVE_SPAN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [OW-1:0] OP_GET      = OW'(4);
  localparam logic [OW-1:0] OP_ACK      = OW'(0);
  localparam logic [OW-1:0] OP_ACK_DATA = OW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] tgt;
  logic [OW-1:0]    err_opcode;
  logic [SW-1:0]    err_source;
  logic [ZW-1:0]    err_size;

  logic [AW:0]      diff;
  logic [AW-1:0]    off;
  logic             in_range;
  logic [IDX_W-1:0] hit;
  logic             hit_ok;
  logic             miss_ok;
  logic             a_fire;
  logic             d_fire;

  // Borrow out of the subtraction flags addresses below the window.
  always_comb begin
    diff     = {1'b0, m_a_address} - BASE;
    off      = diff[AW-1:0];
    in_range = !diff[AW] && (off < TOP_SPAN);
    hit      = IDX_W'(off / SPAN);
    hit_ok   = in_range && ((state == IDLE) ||
               ((state == BUSY) && (hit == tgt) && (cnt < CNT_MAX)));
    miss_ok  = !in_range && (state == IDLE);
    a_fire   = m_a_valid && m_a_ready;
    d_fire   = m_d_valid && m_d_ready;
  end

  always_comb begin
    m_a_ready   = 1'b0;
    s_a_valid   = '0;
    s_a_opcode  = '0;
    s_a_param   = '0;
    s_a_address = '0;
    s_a_size    = '0;
    s_a_mask    = '0;
    s_a_data    = '0;
    s_a_source  = '0;
    if (!rst) begin
      if (miss_ok) m_a_ready = 1'b1;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (hit_ok && int'(hit) == i) begin
          m_a_ready                 = s_a_ready[i];
          s_a_valid[i]              = m_a_valid;
          s_a_opcode[i*OW +: OW]    = m_a_opcode;
          s_a_param[i*PW +: PW]     = m_a_param;
          s_a_address[i*AW +: AW]   = m_a_address;
          s_a_size[i*ZW +: ZW]      = m_a_size;
          s_a_mask[i*MW +: MW]      = m_a_mask;
          s_a_data[i*DW +: DW]      = m_a_data;
          s_a_source[i*SW +: SW]    = m_a_source;
        end
      end
    end
  end

  always_comb begin
    m_d_valid  = 1'b0;
    m_d_opcode = '0;
    m_d_param  = '0;
    m_d_size   = '0;
    m_d_sink   = '0;
    m_d_source = '0;
    m_d_data   = '0;
    m_d_error  = 1'b0;
    s_d_ready  = '0;
    if (!rst) begin
      case (state)
        BUSY: begin
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(tgt) == i) begin
              m_d_valid    = s_d_valid[i];
              m_d_opcode   = s_d_opcode[i*OW +: OW];
              m_d_param    = s_d_param[i*PW +: PW];
              m_d_size     = s_d_size[i*ZW +: ZW];
              m_d_sink     = s_d_sink[i*KW +: KW];
              m_d_source   = s_d_source[i*SW +: SW];
              m_d_data     = s_d_data[i*DW +: DW];
              m_d_error    = s_d_error[i];
              s_d_ready[i] = m_d_ready;
            end
          end
        end
        ERR: begin
          m_d_valid  = 1'b1;
          m_d_error  = 1'b1;
          m_d_opcode = err_opcode;
          m_d_source = err_source;
          m_d_size   = err_size;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      tgt            <= '0;
      err_opcode     <= '0;
      err_source     <= '0;
      err_size       <= '0;
      decode_err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire && in_range) begin
            tgt   <= hit;
            cnt   <= CNT_W'(1);
            state <= BUSY;
          end else if (a_fire) begin
            err_opcode <= (m_a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
            err_source <= m_a_source;
            err_size   <= m_a_size;
            state      <= ERR;
            if (decode_err_cnt != 8'hff)
              decode_err_cnt <= decode_err_cnt + 8'd1;
          end
        end
        BUSY: begin
          if (a_fire && !d_fire) begin
            cnt <= cnt + 1'b1;
          end else if (d_fire && !a_fire) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= IDLE;
          end
        end
        ERR: begin
          if (d_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_ul_demux_1mns.sv
// Scoreboarded bench for tilelink_ul_demux_1mns: directed routing,
// back-pressure, decode-error and reset scenarios.
module tb_tilelink_ul_demux_1mns;

  localparam int N = 3;
  localparam logic [2:0] PUT = 3'd0;
  localparam logic [2:0] GET = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic         m_a_valid;
  logic [2:0]   m_a_opcode;
  logic [2:0]   m_a_param;
  logic [63:0]  m_a_address;
  logic [7:0]   m_a_size;
  logic [7:0]   m_a_mask;
  logic [63:0]  m_a_data;
  logic [2:0]   m_a_source;
  logic         m_a_ready;
  logic         m_d_valid;
  logic [2:0]   m_d_opcode;
  logic [2:0]   m_d_param;
  logic [7:0]   m_d_size;
  logic [2:0]   m_d_sink;
  logic [2:0]   m_d_source;
  logic [63:0]  m_d_data;
  logic         m_d_error;
  logic         m_d_ready;
  logic [N-1:0]    s_a_valid;
  logic [N*3-1:0]  s_a_opcode;
  logic [N*3-1:0]  s_a_param;
  logic [N*64-1:0] s_a_address;
  logic [N*8-1:0]  s_a_size;
  logic [N*8-1:0]  s_a_mask;
  logic [N*64-1:0] s_a_data;
  logic [N*3-1:0]  s_a_source;
  logic [N-1:0]    s_a_ready;
  logic [N-1:0]    s_d_valid;
  logic [N*3-1:0]  s_d_opcode;
  logic [N*3-1:0]  s_d_param;
  logic [N*8-1:0]  s_d_size;
  logic [N*3-1:0]  s_d_sink;
  logic [N*3-1:0]  s_d_source;
  logic [N*64-1:0] s_d_data;
  logic [N-1:0]    s_d_error;
  logic [N-1:0]    s_d_ready;
  logic [7:0]      decode_err_cnt;

  tilelink_ul_demux_1mns dut (
    .clk(clk), .rst(rst),
    .m_a_valid(m_a_valid), .m_a_opcode(m_a_opcode),
    .m_a_param(m_a_param), .m_a_address(m_a_address),
    .m_a_size(m_a_size), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_a_source(m_a_source),
    .m_a_ready(m_a_ready),
    .m_d_valid(m_d_valid), .m_d_opcode(m_d_opcode),
    .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_sink(m_d_sink), .m_d_source(m_d_source),
    .m_d_data(m_d_data), .m_d_error(m_d_error),
    .m_d_ready(m_d_ready),
    .s_a_valid(s_a_valid), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_address(s_a_address),
    .s_a_size(s_a_size), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_source(s_a_source),
    .s_a_ready(s_a_ready),
    .s_d_valid(s_d_valid), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_sink(s_d_sink), .s_d_source(s_d_source),
    .s_d_data(s_d_data), .s_d_error(s_d_error),
    .s_d_ready(s_d_ready),
    .decode_err_cnt(decode_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [63:0] data;
    logic        err;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] src, input logic [63:0] data,
                      input logic err, input logic [2:0] op);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.err  = err;
    e.op   = op;
    sb.push_back(e);
  endtask

  task automatic a_drive(input logic [2:0] op, input logic [63:0] addr,
                         input logic [2:0] src);
    m_a_valid   = 1'b1;
    m_a_opcode  = op;
    m_a_param   = 3'd0;
    m_a_address = addr;
    m_a_size    = 8'd3;
    m_a_mask    = 8'hff;
    m_a_data    = 64'hc0de_0000_0000_0000 | addr;
    m_a_source  = src;
  endtask

  task automatic a_idle();
    m_a_valid = 1'b0;
  endtask

  task automatic d_drive(input int i, input logic v, input logic [2:0] op,
                         input logic [2:0] src, input logic [63:0] data);
    s_d_valid[i]          = v;
    s_d_opcode[i*3 +: 3]  = op;
    s_d_param[i*3 +: 3]   = 3'd0;
    s_d_size[i*8 +: 8]    = 8'd3;
    s_d_sink[i*3 +: 3]    = 3'd0;
    s_d_source[i*3 +: 3]  = src;
    s_d_data[i*64 +: 64]  = data;
    s_d_error[i]          = 1'b0;
  endtask

  // D-channel monitor: every master D handshake pops one expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && m_d_valid && m_d_ready) begin
      if (sb.size() == 0) begin
        chk("d_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d_source", 64'(m_d_source), 64'(e.src));
        chk("d_data",   m_d_data,        e.data);
        chk("d_error",  64'(m_d_error),  64'(e.err));
        chk("d_opcode", 64'(m_d_opcode), 64'(e.op));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_drive(GET, 64'h10, 3'd0);
    s_a_ready = '1;
    m_d_ready = 1'b1;
    for (int i = 0; i < N; i++) d_drive(i, 1'b1, 3'd1, 3'd0, 64'h5);
    @(negedge clk); #1;
    chk("rst_a_ready", 64'(m_a_ready), 64'd0);
    chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rst_d_valid", 64'(m_d_valid), 64'd0);
    chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("rst_err_cnt", 64'(decode_err_cnt), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    a_idle();
    for (int i = 0; i < N; i++) d_drive(i, 1'b0, 3'd0, 3'd0, 64'd0);

    // Get routed to slave 1
    @(negedge clk);
    a_drive(GET, 64'h210, 3'd5);
    push(3'd5, 64'habcd, 1'b0, 3'd1);
    #1;
    chk("get_s_a_valid", 64'(s_a_valid), 64'b010);
    chk("get_a_ready", 64'(m_a_ready), 64'd1);
    chk("get_s1_addr", s_a_address[64 +: 64], 64'h210);
    chk("get_s1_src", 64'(s_a_source[3 +: 3]), 64'd5);
    chk("get_s0_addr", s_a_address[0 +: 64], 64'd0);
    @(negedge clk);
    a_idle();
    d_drive(1, 1'b1, 3'd1, 3'd5, 64'habcd);
    d_drive(0, 1'b1, 3'd0, 3'd2, 64'hdead);
    #1;
    chk("get_d_valid", 64'(m_d_valid), 64'd1);
    chk("get_s_d_ready", 64'(s_d_ready), 64'b010);
    @(negedge clk);
    d_drive(1, 1'b0, 3'd0, 3'd0, 64'd0);
    #1;
    chk("idle_d_valid", 64'(m_d_valid), 64'd0);
    chk("idle_d_data", m_d_data, 64'd0);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);

    // Outstanding limit: two Puts accepted, third stalls
    @(negedge clk);
    a_drive(PUT, 64'h010, 3'd1);
    push(3'd1, 64'd0, 1'b0, 3'd0);
    #1 chk("put1_ready", 64'(m_a_ready), 64'd1);
    @(negedge clk);
    a_drive(PUT, 64'h010, 3'd2);
    push(3'd2, 64'd0, 1'b0, 3'd0);
    #1 chk("put2_ready", 64'(m_a_ready), 64'd1);
    @(negedge clk);
    a_drive(PUT, 64'h020, 3'd3);
    push(3'd3, 64'd0, 1'b0, 3'd0);
    #1;
    chk("put3_stall", 64'(m_a_ready), 64'd0);
    chk("put3_s_a_valid", 64'(s_a_valid), 64'd0);
    @(negedge clk);
    d_drive(0, 1'b1, 3'd0, 3'd1, 64'd0);
    #1 chk("put3_stall_d", 64'(m_a_ready), 64'd0);
    @(negedge clk);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);
    #1;
    chk("put3_ready", 64'(m_a_ready), 64'd1);
    chk("put3_route", 64'(s_a_valid), 64'b001);
    @(negedge clk);
    a_idle();
    d_drive(0, 1'b1, 3'd0, 3'd2, 64'd0);
    @(negedge clk);
    d_drive(0, 1'b1, 3'd0, 3'd3, 64'd0);
    @(negedge clk);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);
    #1 chk("put_drain", 64'(m_d_valid), 64'd0);

    // Simultaneous A and D fire at cnt=1
    @(negedge clk);
    a_drive(PUT, 64'h010, 3'd4);
    push(3'd4, 64'd0, 1'b0, 3'd0);
    @(negedge clk);
    a_drive(PUT, 64'h018, 3'd6);
    push(3'd6, 64'd0, 1'b0, 3'd0);
    d_drive(0, 1'b1, 3'd0, 3'd4, 64'd0);
    #1;
    chk("both_a_ready", 64'(m_a_ready), 64'd1);
    chk("both_d_valid", 64'(m_d_valid), 64'd1);
    @(negedge clk);
    a_drive(GET, 64'h210, 3'd7);
    push(3'd7, 64'h77, 1'b0, 3'd1);
    d_drive(0, 1'b1, 3'd0, 3'd6, 64'd0);
    #1 chk("both_busy_stall", 64'(m_a_ready), 64'd0);
    @(negedge clk);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);
    #1;
    chk("both_cnt1_ready", 64'(m_a_ready), 64'd1);
    chk("both_cnt1_route", 64'(s_a_valid), 64'b010);
    @(negedge clk);
    a_idle();
    d_drive(1, 1'b1, 3'd1, 3'd7, 64'h77);
    @(negedge clk);
    d_drive(1, 1'b0, 3'd0, 3'd0, 64'd0);

    // Different-target Get waits for drain
    @(negedge clk);
    a_drive(GET, 64'h010, 3'd1);
    push(3'd1, 64'h11, 1'b0, 3'd1);
    @(negedge clk);
    a_drive(GET, 64'h410, 3'd2);
    push(3'd2, 64'h22, 1'b0, 3'd1);
    #1;
    chk("xtgt_stall", 64'(m_a_ready), 64'd0);
    chk("xtgt_s_a_valid", 64'(s_a_valid), 64'd0);
    @(negedge clk);
    d_drive(0, 1'b1, 3'd1, 3'd1, 64'h11);
    #1 chk("xtgt_stall_d", 64'(m_a_ready), 64'd0);
    @(negedge clk);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);
    #1;
    chk("xtgt_route", 64'(s_a_valid), 64'b100);
    chk("xtgt_s2_addr", s_a_address[128 +: 64], 64'h410);
    @(negedge clk);
    a_idle();
    d_drive(2, 1'b1, 3'd1, 3'd2, 64'h22);
    @(negedge clk);
    d_drive(2, 1'b0, 3'd0, 3'd0, 64'd0);

    // Unmapped Get -> local error response
    @(negedge clk);
    m_d_ready = 1'b0;
    a_drive(GET, 64'h700, 3'd3);
    #1;
    chk("miss_ready", 64'(m_a_ready), 64'd1);
    chk("miss_s_a_valid", 64'(s_a_valid), 64'd0);
    @(negedge clk);
    a_idle();
    #1;
    chk("err_valid", 64'(m_d_valid), 64'd1);
    chk("err_opcode", 64'(m_d_opcode), 64'd1);
    chk("err_error", 64'(m_d_error), 64'd1);
    chk("err_source", 64'(m_d_source), 64'd3);
    chk("err_size", 64'(m_d_size), 64'd3);
    chk("err_data", m_d_data, 64'd0);
    chk("err_a_ready", 64'(m_a_ready), 64'd0);
    chk("err_cnt1", 64'(decode_err_cnt), 64'd1);
    @(negedge clk);
    push(3'd3, 64'd0, 1'b1, 3'd1);
    m_d_ready = 1'b1;
    #1 chk("err_hold", 64'(m_d_valid), 64'd1);
    @(negedge clk);
    #1 chk("err_done", 64'(m_d_valid), 64'd0);

    // Unmapped Put, then saturate the error counter
    @(negedge clk);
    a_drive(PUT, 64'h1000, 3'd6);
    push(3'd6, 64'd0, 1'b1, 3'd0);
    @(negedge clk);
    a_idle();
    @(negedge clk);
    #1 chk("err_cnt2", 64'(decode_err_cnt), 64'd2);
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      a_drive(PUT, 64'h800, k[2:0]);
      push(k[2:0], 64'd0, 1'b1, 3'd0);
      @(negedge clk);
      a_idle();
      if (k == 252) begin
        #1 chk("err_cnt255", 64'(decode_err_cnt), 64'd255);
      end
    end
    @(negedge clk);
    #1 chk("err_cnt_sat", 64'(decode_err_cnt), 64'd255);

    // Reset while BUSY with cnt=2
    @(negedge clk);
    a_drive(PUT, 64'h010, 3'd1);
    push(3'd1, 64'd0, 1'b0, 3'd0);
    @(negedge clk);
    a_drive(PUT, 64'h010, 3'd2);
    push(3'd2, 64'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    a_drive(GET, 64'h210, 3'd5);
    d_drive(0, 1'b1, 3'd0, 3'd1, 64'd0);
    #1;
    chk("mrst_a_ready", 64'(m_a_ready), 64'd0);
    chk("mrst_d_valid", 64'(m_d_valid), 64'd0);
    chk("mrst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("mrst_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("mrst_err_cnt", 64'(decode_err_cnt), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    a_idle();
    #1;
    chk("stale_d_valid", 64'(m_d_valid), 64'd0);
    chk("stale_s_d_ready", 64'(s_d_ready), 64'd0);
    @(negedge clk);
    a_drive(GET, 64'h010, 3'd4);
    push(3'd4, 64'h44, 1'b0, 3'd1);
    #1 chk("stale_pre_fire", 64'(m_d_valid), 64'd0);
    @(negedge clk);
    a_idle();
    d_drive(0, 1'b1, 3'd1, 3'd4, 64'h44);
    #1 chk("post_rst_d_valid", 64'(m_d_valid), 64'd1);
    @(negedge clk);
    d_drive(0, 1'b0, 3'd0, 3'd0, 64'd0);
    #1 chk("post_rst_idle", 64'(m_d_valid), 64'd0);

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
